// File: rtl/prbs_checker_if.sv
// PRBS checker port bundle.
// Carries the received serial stream and the checker status outputs.
//   din        : received serial PRBS bit
//   din_valid  : din is sampled only when high
//   err_clr    : synchronous clear of err_count
//   locked     : checker is synchronised to the stream
//   err_pulse  : one-cycle strobe per counted bit error
//   err_count  : saturating count of errors seen while locked (CW bits)
//   zero_stuck : history register all zeros while verifying/locked
// CW here must equal the CW of the prbs_checker instance it is bound to.
interface prbs_checker_if #(
    parameter int unsigned CW = 16
);
    logic          din;
    logic          din_valid;
    logic          err_clr;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic          zero_stuck;

    // Stream source / status consumer side.
    modport master (
        output din,
        output din_valid,
        output err_clr,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  zero_stuck
    );

    // Checker side.
    modport slave (
        input  din,
        input  din_valid,
        input  err_clr,
        output locked,
        output err_pulse,
        output err_count,
        output zero_stuck
    );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker.
// Seeds its history from the incoming stream, verifies LOCK_CNT consecutive
// predicted bits, then free-runs its own generator and counts bit errors.
// Recurrence: b[k] = b[k-N] ^ b[k-TAP].
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : prbs_checker_if slave (din/din_valid/err_clr in,
//             locked/err_pulse/err_count/zero_stuck out)
module prbs_checker #(
    parameter int unsigned N        = 3,
    parameter int unsigned TAP      = 2,
    parameter int unsigned LOCK_CNT = 8,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CW       = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    prbs_checker_if.slave  bus
);

    localparam int unsigned SW = $clog2(N + 1);

    typedef enum logic [1:0] {
        StSeed,
        StVerify,
        StLocked
    } state_e;

    state_e        state_q, state_d;
    // Bit 0 is the newest accepted bit (hist[1]); bit N-1 is hist[N].
    logic [N-1:0]  hist_q, hist_d;
    logic [SW-1:0] seed_cnt_q, seed_cnt_d;
    logic [7:0]    match_cnt_q, match_cnt_d;
    logic [7:0]    miss_cnt_q, miss_cnt_d;
    logic          err_pulse_q, err_pulse_d;
    logic [CW-1:0] err_count_q, err_count_d;

    logic exp_bit;
    logic hist_zero;
    logic count_err;

    assign exp_bit   = hist_q[N-1] ^ hist_q[TAP-1];
    assign hist_zero = (hist_q == '0);

    // Next-state for the FSM, history and internal counters.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_pulse_d = 1'b0;
        count_err   = 1'b0;

        if (bus.din_valid) begin
            unique case (state_q)
                StSeed: begin
                    hist_d = {hist_q[N-2:0], bus.din};
                    if (seed_cnt_q == SW'(N - 1)) begin
                        state_d     = StVerify;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 1'b1;
                    end
                end

                StVerify: begin
                    hist_d = {hist_q[N-2:0], bus.din};
                    if (hist_zero || (bus.din != exp_bit)) begin
                        // All-zero history is a degenerate generator state: reseed.
                        state_d     = StSeed;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else if (match_cnt_q == 8'(LOCK_CNT - 1)) begin
                        state_d     = StLocked;
                        match_cnt_d = '0;
                        miss_cnt_d  = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end
                end

                StLocked: begin
                    // Free-run on the prediction so one bad bit is one error.
                    hist_d = {hist_q[N-2:0], exp_bit};
                    if (bus.din != exp_bit) begin
                        count_err   = 1'b1;
                        err_pulse_d = 1'b1;
                        if (miss_cnt_q == 8'(LOSS_CNT - 1)) begin
                            state_d    = StSeed;
                            seed_cnt_d = '0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 8'd1;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end

                default: begin
                    state_d    = StSeed;
                    seed_cnt_d = '0;
                end
            endcase
        end
    end

    // Error counter: clear wins over old value, a same-cycle error lands as 1.
    always_comb begin
        err_count_d = err_count_q;
        if (bus.err_clr) begin
            err_count_d = '0;
        end
        if (count_err) begin
            if (bus.err_clr) begin
                err_count_d    = '0;
                err_count_d[0] = 1'b1;
            end else if (!(&err_count_q)) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StSeed;
            hist_q      <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.locked     = (state_q == StLocked);
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_count  = err_count_q;
    assign bus.zero_stuck = hist_zero && (state_q != StSeed);

endmodule

// File: tb/tb_prbs_checker.sv
// Directed testbench for prbs_checker (N=3, TAP=2, LOCK_CNT=8, LOSS_CNT=3).
// Stream 1001011 repeating. A second instance with CW=4 shares the stimulus
// so that counter saturation can be reached in a few cycles.
module tb_prbs_checker;

    logic clk;
    logic reset_n;

    prbs_checker_if #(.CW(16)) bus_if ();
    prbs_checker_if #(.CW(4))  sat_if ();

    prbs_checker #(
        .N        (3),
        .TAP      (2),
        .LOCK_CNT (8),
        .LOSS_CNT (3),
        .CW       (16)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    prbs_checker #(
        .N        (3),
        .TAP      (2),
        .LOCK_CNT (8),
        .LOSS_CNT (3),
        .CW       (4)
    ) u_dut_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sat_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int k;
    logic [0:6] pat;
    logic seen_lock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus to both instances; outputs sampled 1 ns after the edge.
    task automatic send(input logic d, input logic v, input logic clr);
        bus_if.din       = d;
        bus_if.din_valid = v;
        bus_if.err_clr   = clr;
        sat_if.din       = d;
        sat_if.din_valid = v;
        sat_if.err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_ref(input logic inv, input logic clr);
        send(pat[k % 7] ^ inv, 1'b1, clr);
        k++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        k = 0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        k       = 0;
        pat     = 7'b1001011;
        reset_n = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_locked", 32'(bus_if.locked), 32'd0);
        check_eq("rst_pulse", 32'(bus_if.err_pulse), 32'd0);
        check_eq("rst_count", 32'(bus_if.err_count), 32'd0);
        check_eq("rst_zero", 32'(bus_if.zero_stuck), 32'd0);

        // Clean lock: 3 seed + 8 matches
        for (int i = 0; i < 10; i++) send_ref(1'b0, 1'b0);
        check_eq("lock_pre11", 32'(bus_if.locked), 32'd0);
        send_ref(1'b0, 1'b0);
        check_eq("lock_at11", 32'(bus_if.locked), 32'd1);
        check_eq("lock_count", 32'(bus_if.err_count), 32'd0);
        check_eq("lock_zero", 32'(bus_if.zero_stuck), 32'd0);
        for (int i = 0; i < 5; i++) send_ref(1'b0, 1'b0);
        check_eq("clean_pulse", 32'(bus_if.err_pulse), 32'd0);
        check_eq("clean_count", 32'(bus_if.err_count), 32'd0);

        // Single corrupted bit
        send_ref(1'b1, 1'b0);
        check_eq("single_pulse", 32'(bus_if.err_pulse), 32'd1);
        check_eq("single_count", 32'(bus_if.err_count), 32'd1);
        check_eq("single_locked", 32'(bus_if.locked), 32'd1);
        send_ref(1'b0, 1'b0);
        check_eq("single_pulse_off", 32'(bus_if.err_pulse), 32'd0);
        for (int i = 0; i < 6; i++) send_ref(1'b0, 1'b0);
        check_eq("single_count_hold", 32'(bus_if.err_count), 32'd1);

        // Clear on an idle cycle, then three consecutive errors drop lock
        send(1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b0);
        check_eq("clr_count", 32'(bus_if.err_count), 32'd0);
        check_eq("idle_locked", 32'(bus_if.locked), 32'd1);
        send_ref(1'b1, 1'b0);
        send_ref(1'b1, 1'b0);
        check_eq("burst2_locked", 32'(bus_if.locked), 32'd1);
        send_ref(1'b1, 1'b0);
        check_eq("burst3_count", 32'(bus_if.err_count), 32'd3);
        check_eq("burst3_locked", 32'(bus_if.locked), 32'd0);
        check_eq("burst3_pulse", 32'(bus_if.err_pulse), 32'd1);
        for (int i = 0; i < 10; i++) send_ref(1'b0, 1'b0);
        check_eq("relock_pre11", 32'(bus_if.locked), 32'd0);
        send_ref(1'b0, 1'b0);
        check_eq("relock_at11", 32'(bus_if.locked), 32'd1);
        check_eq("relock_count", 32'(bus_if.err_count), 32'd3);

        // Valid toggling 1010...: lock still after 11 valid bits
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_ref(1'b0, 1'b0);
            send(~pat[k % 7], 1'b0, 1'b0);
        end
        check_eq("tog_pre11", 32'(bus_if.locked), 32'd0);
        send_ref(1'b0, 1'b0);
        check_eq("tog_at11", 32'(bus_if.locked), 32'd1);
        send(~pat[k % 7], 1'b0, 1'b0);
        check_eq("tog_idle_locked", 32'(bus_if.locked), 32'd1);
        check_eq("tog_idle_count", 32'(bus_if.err_count), 32'd0);

        // Constant zero stream
        do_reset();
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 1'b0);
        check_eq("zero_stuck", 32'(bus_if.zero_stuck), 32'd1);
        check_eq("zero_locked", 32'(bus_if.locked), 32'd0);
        seen_lock = 1'b0;
        for (int i = 0; i < 40; i++) begin
            send(1'b0, 1'b1, 1'b0);
            seen_lock = seen_lock | bus_if.locked;
        end
        check_eq("zero_never_lock", 32'(seen_lock), 32'd0);
        check_eq("zero_count", 32'(bus_if.err_count), 32'd0);

        // Saturation on the CW=4 instance, count tracking on the CW=16 one
        do_reset();
        for (int i = 0; i < 11; i++) send_ref(1'b0, 1'b0);
        check_eq("sat_lock", 32'(sat_if.locked), 32'd1);
        for (int i = 0; i < 8; i++) begin
            send_ref(1'b1, 1'b0);
            send_ref(1'b1, 1'b0);
            send_ref(1'b0, 1'b0);
        end
        check_eq("sat_count_15", 32'(sat_if.err_count), 32'd15);
        check_eq("wide_count_16", 32'(bus_if.err_count), 32'd16);
        check_eq("sat_still_locked", 32'(bus_if.locked), 32'd1);
        send_ref(1'b1, 1'b0);
        check_eq("sat_hold", 32'(sat_if.err_count), 32'd15);
        check_eq("wide_count_17", 32'(bus_if.err_count), 32'd17);
        send_ref(1'b1, 1'b1);
        check_eq("clr_err_wide", 32'(bus_if.err_count), 32'd1);
        check_eq("clr_err_sat", 32'(sat_if.err_count), 32'd1);
        check_eq("clr_err_pulse", 32'(bus_if.err_pulse), 32'd1);

        // Asynchronous reset while locked with a pulse pending
        check_eq("pre_rst_locked", 32'(bus_if.locked), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_locked", 32'(bus_if.locked), 32'd0);
        check_eq("arst_pulse", 32'(bus_if.err_pulse), 32'd0);
        check_eq("arst_count", 32'(bus_if.err_count), 32'd0);
        check_eq("arst_zero", 32'(bus_if.zero_stuck), 32'd0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter N, default 3: generator register length, 3..32.
REQ-002 Parameter TAP, default 2: second feedback tap index, 1..N-1; recurrence is b[k] = b[k-N] ^ b[k-TAP].
REQ-003 Parameter LOCK_CNT, default 8: consecutive matches needed to declare lock, 1..255.
REQ-004 Parameter LOSS_CNT, default 3: consecutive mismatches in lock that drop lock, 1..255.
REQ-005 Parameter CW, default 16: error counter width.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 din  input  1  received serial PRBS bit.
REQ-009 din_valid  input  1  din is sampled only on cycles where this is high.
REQ-010 err_clr  input  1  synchronous clear of err_count.
REQ-011 locked  output  1  checker is synchronised to the stream.
REQ-012 err_pulse  output  1  one-cycle strobe per bit error counted.
REQ-013 err_count  output  CW  saturating count of bit errors counted while locked.
REQ-014 zero_stuck  output  1  history register is all zeros (degenerate stream).

Function
REQ-015 History register hist[1:N] SHALL hold the last N accepted bits, hist[1] newest; cycles with din_valid=0 SHALL change no state, no counters and no outputs except clearing err_pulse.
REQ-016 Expected bit SHALL be exp = hist[N] ^ hist[TAP].
REQ-017 FSM states: SEED, VERIFY, LOCKED.
REQ-018 SEED: each valid bit shifts din into hist; after N valid bits -> VERIFY with match counter = 0.
REQ-019 VERIFY: each valid bit shifts din into hist; din==exp increments match counter; on reaching LOCK_CNT -> LOCKED; din!=exp -> SEED with seed count restarted at 0.
REQ-020 LOCKED: each valid bit shifts exp (not din) into hist, so a single corrupted bit is counted exactly once.
REQ-021 LOCKED, din!=exp: err_pulse high for exactly the next cycle; err_count +1, saturating at 2^CW-1; consecutive-mismatch counter +1.
REQ-022 LOCKED, din==exp: consecutive-mismatch counter = 0.
REQ-023 Consecutive-mismatch counter reaching LOSS_CNT -> SEED; that final mismatch is still counted and pulsed.
REQ-024 Errors are counted only in LOCKED; mismatches in SEED/VERIFY are never counted.
REQ-025 locked = 1 exactly while the state is LOCKED; registered, asserting the cycle after the LOCK_CNT-th match.
REQ-026 zero_stuck = 1 whenever hist is all zeros and state is VERIFY or LOCKED; in VERIFY an all-zero hist SHALL force -> SEED instead of counting matches.
REQ-027 err_clr=1 sets err_count to 0 next cycle; if a counted error occurs in the same cycle, err_count becomes 1.
REQ-028 err_count holds its value across lock loss and relock; cleared only by err_clr or reset.

Reset
REQ-029 reset_n low SHALL immediately force: state SEED, hist all zeros, all internal counters 0, locked 0, err_pulse 0, err_count 0, zero_stuck 0.
REQ-030 Reset deassertion mid-stream SHALL restart from SEED; no partial lock state is retained.

Verification (N=3, TAP=2, LOCK_CNT=8, LOSS_CNT=3, CW=16; reference stream 1001011 repeating)
REQ-031 Clean stream, din_valid=1 every cycle -> locked rises after 3 seed + 8 matching bits (cycle 12 after first valid), err_count stays 0.
REQ-032 Locked, invert one bit -> single err_pulse, err_count=1, locked stays 1, following clean bits produce no further errors.
REQ-033 Locked, invert 3 consecutive bits -> err_count=3, locked falls after third; clean stream relocks after 11 more valid bits with err_count still 3.
REQ-034 Constant din=0 -> zero_stuck=1 after SEED, locked never asserts.
REQ-035 Clean stream with din_valid toggling 1010... -> same lock after 11 valid bits; invalid cycles change nothing.
REQ-036 Force err_count to 0xFFFF via errors, inject another -> stays 0xFFFF; err_clr with simultaneous error -> 1; reset_n pulse while locked -> all outputs 0 immediately.
